// File: rtl/benes_pipe_router.sv
`default_nettype none
// ============================================================================
// Module   : benes_pipe_router
// Purpose  : Parametrised, pipelined PORTS-port Benes interconnect. Each beat
//            carries a bank tag captured at ingress and is routed by that
//            bank's switch settings in every stage. A shadow configuration
//            bank is written stage by stage and swapped in atomically on a
//            commit once every stage has been written.
// Optional : BENES_BYPASS_EN adds i_bypass; a bypass beat is routed as the
//            identity (all switches straight) and never blocks o_cfg_ready.
// Ports    : clk, rstn (async active-low)
//            i_cfg_valid/o_cfg_ready/i_cfg_stage/i_cfg_bits : shadow writes
//            i_cfg_commit  : swap shadow and active banks
//            o_cfg_err     : one-cycle pulse on rejected write or commit
//            o_active_bank : bank tag applied to beats entering now
//            i_valid/i_data: ingress beat, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//            o_valid/o_data: routed beat, LAT cycles after ingress
// Revision : 1.0 - initial release
// ============================================================================
module benes_pipe_router #(
  parameter int PORTS      = 32,
  parameter int DATA_WIDTH = 512,
  parameter int PIPE_EVERY = 1
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   i_cfg_valid,
  output logic                                   o_cfg_ready,
  input  logic [$clog2(2*$clog2(PORTS)-1)-1:0]   i_cfg_stage,
  input  logic [PORTS/2-1:0]                     i_cfg_bits,
  input  logic                                   i_cfg_commit,
  output logic                                   o_cfg_err,
  output logic                                   o_active_bank,
`ifdef BENES_BYPASS_EN
  input  logic                                   i_bypass,
`endif
  input  logic                                   i_valid,
  input  logic [PORTS*DATA_WIDTH-1:0]            i_data,
  output logic                                   o_valid,
  output logic [PORTS*DATA_WIDTH-1:0]            o_data
);

  localparam int LOGP   = $clog2(PORTS);
  localparam int STAGES = 2*LOGP - 1;
  localparam int MID    = LOGP - 1;
  localparam int SW     = PORTS / 2;
  localparam int BUSW   = PORTS * DATA_WIDTH;

  // Destination port at the input of stage s+1 for output port p of stage s.
  // The first half of the network unshuffles ever smaller blocks, the second
  // half shuffles them back, so all-straight switches give the identity.
  function automatic int wire_dest(input int s, input int p);
    int r;
    int b;
    int q;
    if (s < MID) r = PORTS >> s;
    else         r = PORTS >> (STAGES - 2 - s);
    b = p - (p % r);
    q = p % r;
    if (s < MID) return b + q/2 + (q%2)*(r/2);
    return b + 2*(q % (r/2)) + q/(r/2);
  endfunction

  // --------------------------------------------------------------------------
  // Configuration banks
  // --------------------------------------------------------------------------
  logic [SW-1:0]     bank [2][STAGES];
  logic [STAGES-1:0] mask;
  logic              active;
  logic              cfg_err_q;
  logic [STAGES-1:0] busy;

  logic              wr_acc;
  logic              wr_ok;
  logic              wr_bad;
  logic [STAGES-1:0] wr_onehot;
  logic              mask_full;
  logic              commit_ok;
  logic              commit_bad;

  assign o_cfg_ready   = ~|busy;
  assign o_cfg_err     = cfg_err_q;
  assign o_active_bank = active;

  always_comb begin
    wr_acc    = i_cfg_valid && o_cfg_ready;
    wr_onehot = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (int'(i_cfg_stage) == s) wr_onehot[s] = wr_acc;
    end
    wr_ok      = |wr_onehot;
    wr_bad     = wr_acc && !wr_ok;
    // A write accepted in the commit cycle counts toward completeness.
    mask_full  = &(mask | wr_onehot);
    commit_ok  = i_cfg_commit && mask_full;
    commit_bad = i_cfg_commit && !mask_full;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < STAGES; s++) begin
          bank[b][s] <= '0;
        end
      end
      mask      <= '0;
      active    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (wr_onehot[s]) bank[~active][s] <= i_cfg_bits;
      end
      if (commit_ok) mask <= '0;
      else           mask <= mask | wr_onehot;
      active    <= active ^ commit_ok;
      cfg_err_q <= wr_bad | commit_bad;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: stage inputs, index 0 is the ingress
  // --------------------------------------------------------------------------
  logic [BUSW-1:0] st_in  [STAGES];
  logic            vld_in [STAGES];
  logic            tag_in [STAGES];
  logic            byp_in [STAGES];

  assign st_in[0]  = i_data;
  assign vld_in[0] = i_valid;
  assign tag_in[0] = active;
`ifdef BENES_BYPASS_EN
  assign byp_in[0] = i_bypass;
`else
  assign byp_in[0] = 1'b0;
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [SW-1:0]   sel;
    logic [BUSW-1:0] swd;
    logic [BUSW-1:0] wired;
    logic [BUSW-1:0] d_nx;
    logic            v_nx;
    logic            t_nx;
    logic            b_nx;

    assign sel = byp_in[s] ? '0 : bank[tag_in[s]][s];

    for (genvar k = 0; k < SW; k++) begin : g_sw
      assign swd[(2*k)*DATA_WIDTH +: DATA_WIDTH] = sel[k]
          ? st_in[s][(2*k+1)*DATA_WIDTH +: DATA_WIDTH]
          : st_in[s][(2*k)*DATA_WIDTH +: DATA_WIDTH];
      assign swd[(2*k+1)*DATA_WIDTH +: DATA_WIDTH] = sel[k]
          ? st_in[s][(2*k)*DATA_WIDTH +: DATA_WIDTH]
          : st_in[s][(2*k+1)*DATA_WIDTH +: DATA_WIDTH];
    end

    if (s < STAGES-1) begin : g_wire
      for (genvar p = 0; p < PORTS; p++) begin : g_port
        localparam int DEST = wire_dest(s, p);
        assign wired[DEST*DATA_WIDTH +: DATA_WIDTH] = swd[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin : g_last
      assign wired = swd;
    end

    if (((s+1) % PIPE_EVERY == 0) || (s == STAGES-1)) begin : g_reg
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          d_nx <= '0;
          v_nx <= 1'b0;
          t_nx <= 1'b0;
          b_nx <= 1'b0;
        end else begin
          d_nx <= wired;
          v_nx <= vld_in[s];
          t_nx <= tag_in[s];
          b_nx <= byp_in[s];
        end
      end
      // Only valid, non-bypass beats of the shadow bank hold off writes.
      assign busy[s] = v_nx && !b_nx && (t_nx != active);
    end else begin : g_comb
      assign d_nx    = wired;
      assign v_nx    = vld_in[s];
      assign t_nx    = tag_in[s];
      assign b_nx    = byp_in[s];
      assign busy[s] = 1'b0;
    end

    if (s < STAGES-1) begin : g_fwd
      assign st_in[s+1]  = d_nx;
      assign vld_in[s+1] = v_nx;
      assign tag_in[s+1] = t_nx;
      assign byp_in[s+1] = b_nx;
    end else begin : g_out
      assign o_data  = d_nx;
      assign o_valid = v_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_benes_pipe_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_benes_pipe_router
// Purpose  : Self-checking bench for benes_pipe_router. Instance A uses
//            PORTS=32/PIPE_EVERY=1 (LAT=9), instance B PORTS=8/PIPE_EVERY=2
//            (LAT=3); both with 16-bit ports. Expected beats are queued at
//            ingress and compared, with their latency, when they emerge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_benes_pipe_router;

  localparam int DW   = 16;
  localparam int PA   = 32;
  localparam int LATA = 9;
  localparam int STA  = 9;
  localparam int PB   = 8;
  localparam int LATB = 3;
  localparam int STB  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;
  int   cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A
  logic              a_cfg_valid, a_cfg_ready, a_cfg_commit, a_cfg_err, a_active;
  logic [3:0]        a_cfg_stage;
  logic [15:0]       a_cfg_bits;
  logic              a_valid, a_ovalid;
  logic [PA*DW-1:0]  a_data, a_odata;
  // DUT B
  logic              b_cfg_valid, b_cfg_ready, b_cfg_commit, b_cfg_err, b_active;
  logic [2:0]        b_cfg_stage;
  logic [3:0]        b_cfg_bits;
  logic              b_valid, b_ovalid;
  logic [PB*DW-1:0]  b_data, b_odata;
`ifdef BENES_BYPASS_EN
  logic a_byp = 1'b0;
  logic b_byp = 1'b0;
`endif

  benes_pipe_router #(.PORTS(PA), .DATA_WIDTH(DW), .PIPE_EVERY(1)) u_dut_a (
    .clk(clk), .rstn(rstn),
    .i_cfg_valid(a_cfg_valid), .o_cfg_ready(a_cfg_ready), .i_cfg_stage(a_cfg_stage),
    .i_cfg_bits(a_cfg_bits), .i_cfg_commit(a_cfg_commit), .o_cfg_err(a_cfg_err),
    .o_active_bank(a_active),
`ifdef BENES_BYPASS_EN
    .i_bypass(a_byp),
`endif
    .i_valid(a_valid), .i_data(a_data), .o_valid(a_ovalid), .o_data(a_odata)
  );

  benes_pipe_router #(.PORTS(PB), .DATA_WIDTH(DW), .PIPE_EVERY(2)) u_dut_b (
    .clk(clk), .rstn(rstn),
    .i_cfg_valid(b_cfg_valid), .o_cfg_ready(b_cfg_ready), .i_cfg_stage(b_cfg_stage),
    .i_cfg_bits(b_cfg_bits), .i_cfg_commit(b_cfg_commit), .o_cfg_err(b_cfg_err),
    .o_active_bank(b_active),
`ifdef BENES_BYPASS_EN
    .i_bypass(b_byp),
`endif
    .i_valid(b_valid), .i_data(b_data), .o_valid(b_ovalid), .o_data(b_odata)
  );

  // ------------------------------------------------------------------ model
  logic [8:0][15:0] cfg_a [2];
  logic [8:0]       mask_a;
  logic             act_a;
  logic [8:0][15:0] cfg_b [2];
  logic [4:0]       mask_b;
  logic             act_b;

  typedef struct {
    logic [PA*DW-1:0] d;
    int               c;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  // Forward Benes model: np ports, cfg[s][k] is the cross bit of switch k.
  function automatic logic [31:0][15:0] route(input int np, input logic [8:0][15:0] cfg,
                                              input logic [31:0][15:0] din);
    logic [31:0][15:0] cur, nxt;
    logic [15:0] t;
    int lg, ns, mid, r, b, q, d;
    lg = 0;
    while ((1 << lg) < np) lg++;
    ns  = 2*lg - 1;
    mid = lg - 1;
    cur = din;
    for (int s = 0; s < ns; s++) begin
      for (int k = 0; k < np/2; k++) begin
        if (cfg[s][k]) begin
          t = cur[2*k]; cur[2*k] = cur[2*k+1]; cur[2*k+1] = t;
        end
      end
      if (s < ns-1) begin
        r   = (s < mid) ? (np >> s) : (np >> (ns-2-s));
        nxt = cur;
        for (int p = 0; p < np; p++) begin
          b = p - (p % r);
          q = p % r;
          d = (s < mid) ? (b + q/2 + (q%2)*(r/2)) : (b + 2*(q % (r/2)) + q/(r/2));
          nxt[d] = cur[p];
        end
        cur = nxt;
      end
    end
    return cur;
  endfunction

  function automatic logic [PA*DW-1:0] rand_bus();
    logic [PA*DW-1:0] v;
    for (int i = 0; i < PA*DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // -------------------------------------------------------------- monitors
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (q_a.size() > 0 && q_a[0].c + LATA < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL sb_a_missing: beat from cycle %0d not seen, required at cycle %0d", q_a[0].c, q_a[0].c + LATA);
        void'(q_a.pop_front());
      end
      if (a_ovalid !== 1'b0) begin
        n_tests++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL sb_a_unexpected: o_valid=%b at cycle %0d, required 0", a_ovalid, cyc);
        end else begin
          ea = q_a.pop_front();
          if (a_odata !== ea.d) begin
            n_fail++;
            $display("FAIL sb_a_data: got %h required %h", a_odata, ea.d);
          end
          n_tests++;
          if (cyc !== ea.c + LATA) begin
            n_fail++;
            $display("FAIL sb_a_latency: got %0d cycles required %0d", cyc - ea.c, LATA);
          end
        end
      end
      if (q_b.size() > 0 && q_b[0].c + LATB < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL sb_b_missing: beat from cycle %0d not seen, required at cycle %0d", q_b[0].c, q_b[0].c + LATB);
        void'(q_b.pop_front());
      end
      if (b_ovalid !== 1'b0) begin
        n_tests++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL sb_b_unexpected: o_valid=%b at cycle %0d, required 0", b_ovalid, cyc);
        end else begin
          eb = q_b.pop_front();
          if (b_odata !== eb.d[PB*DW-1:0]) begin
            n_fail++;
            $display("FAIL sb_b_data: got %h required %h", b_odata, eb.d[PB*DW-1:0]);
          end
          n_tests++;
          if (cyc !== eb.c + LATB) begin
            n_fail++;
            $display("FAIL sb_b_latency: got %0d cycles required %0d", cyc - eb.c, LATB);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus on A; e is the expected routed beat when v=1.
  task automatic cycle_a(input bit v, input logic [PA*DW-1:0] d, input logic [PA*DW-1:0] e,
                         input bit wr, input int st, input logic [15:0] bits, input bit cm);
    exp_t t;
    a_valid = v; a_data = d; a_cfg_valid = wr; a_cfg_stage = st[3:0];
    a_cfg_bits = bits; a_cfg_commit = cm;
    if (v) begin t.d = e; t.c = cyc; q_a.push_back(t); end
    if (wr && st < STA) begin cfg_a[~act_a][st] = bits; mask_a[st] = 1'b1; end
    if (cm && (&mask_a)) begin act_a = ~act_a; mask_a = '0; end
    step();
    a_valid = 1'b0; a_cfg_valid = 1'b0; a_cfg_commit = 1'b0;
  endtask

  task automatic cycle_b(input bit v, input logic [PB*DW-1:0] d, input logic [PB*DW-1:0] e,
                         input bit wr, input int st, input logic [3:0] bits, input bit cm);
    exp_t t;
    b_valid = v; b_data = d; b_cfg_valid = wr; b_cfg_stage = st[2:0];
    b_cfg_bits = bits; b_cfg_commit = cm;
    if (v) begin t.d = '0; t.d[PB*DW-1:0] = e; t.c = cyc; q_b.push_back(t); end
    if (wr && st < STB) begin cfg_b[~act_b][st] = {12'h000, bits}; mask_b[st] = 1'b1; end
    if (cm && (&mask_b)) begin act_b = ~act_b; mask_b = '0; end
    step();
    b_valid = 1'b0; b_cfg_valid = 1'b0; b_cfg_commit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_ready_a();
    int w = 0;
    while (a_cfg_ready !== 1'b1 && w < 40) begin step(); w++; end
    n_tests++;
    if (a_cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_a_timeout: o_cfg_ready=%b after %0d cycles, required 1", a_cfg_ready, w);
    end
  endtask

  task automatic program_rand_a(input bit commit);
    wait_ready_a();
    for (int s = 0; s < STA; s++) cycle_a(0, '0, '0, 1, s, 16'($urandom), 0);
    if (commit) cycle_a(0, '0, '0, 0, 0, '0, 1);
  endtask

  task automatic check_drained();
    idle(LATA + 2);
    n_tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d beats outstanding, required 0/0", q_a.size(), q_b.size());
    end
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    n_tests++; if (a_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b required 0", a_ovalid); end
    n_tests++; if (a_odata !== '0) begin n_fail++; $display("FAIL reset_o_data: got %h required 0", a_odata); end
    n_tests++; if (a_cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b required 0", a_cfg_err); end
    n_tests++; if (a_active !== 1'b0) begin n_fail++; $display("FAIL reset_active_bank: got %b required 0", a_active); end
    n_tests++; if (a_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b required 1", a_cfg_ready); end
    n_tests++; if (b_ovalid !== 1'b0 || b_active !== 1'b0) begin n_fail++; $display("FAIL reset_b: o_valid=%b bank=%b required 0/0", b_ovalid, b_active); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_identity();
    logic [PA*DW-1:0] d;
    for (int i = 0; i < 20; i++) begin
      for (int p = 0; p < PA; p++) d[p*DW +: DW] = 16'(p | (i << 8));
      cycle_a(1, d, d, 0, 0, '0, 0);
    end
    check_drained();
  endtask

  task automatic test_stage0_swap();
    logic [PA*DW-1:0] d, e;
    wait_ready_a();
    for (int s = 0; s < STA; s++) cycle_a(0, '0, '0, 1, s, (s == 0) ? 16'hFFFF : 16'h0000, 0);
    cycle_a(0, '0, '0, 0, 0, '0, 1);
    n_tests++; if (a_active !== 1'b1) begin n_fail++; $display("FAIL swap_commit_bank: got %b required 1", a_active); end
    n_tests++; if (a_cfg_err !== 1'b0) begin n_fail++; $display("FAIL swap_commit_err: got %b required 0", a_cfg_err); end
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < PA; p++) d[p*DW +: DW] = 16'(p | (i << 8));
      for (int p = 0; p < PA; p++) e[p*DW +: DW] = d[(p ^ 1)*DW +: DW];
      cycle_a(1, d, e, 0, 0, '0, 0);
    end
    check_drained();
  endtask

  task automatic test_cfg_errors();
    logic prev;
    wait_ready_a();
    prev = act_a;
    for (int s = 0; s < STA-1; s++) cycle_a(0, '0, '0, 1, s, 16'h0000, 0);
    cycle_a(0, '0, '0, 0, 0, '0, 1);
    n_tests++; if (a_cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_partial_commit: got %b required 1", a_cfg_err); end
    n_tests++; if (a_active !== prev) begin n_fail++; $display("FAIL err_partial_bank: got %b required %b", a_active, prev); end
    step();
    n_tests++; if (a_cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: got %b required 0", a_cfg_err); end
    cycle_a(0, '0, '0, 1, 9, 16'hFFFF, 0);
    n_tests++; if (a_cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_bad_stage: got %b required 1", a_cfg_err); end
    cycle_a(0, '0, '0, 0, 0, '0, 1);
    n_tests++; if (a_cfg_err !== 1'b1 || a_active !== prev) begin
      n_fail++; $display("FAIL err_mask_after_bad: err=%b bank=%b required 1/%b", a_cfg_err, a_active, prev);
    end
    // Last stage written in the same cycle as the commit completes the mask.
    cycle_a(0, '0, '0, 1, 8, 16'h0000, 1);
    n_tests++; if (a_cfg_err !== 1'b0 || a_active !== ~prev) begin
      n_fail++; $display("FAIL err_same_cycle_commit: err=%b bank=%b required 0/%b", a_cfg_err, a_active, ~prev);
    end
  endtask

  task automatic test_commit_midstream();
    logic [PA*DW-1:0] d;
    logic want;
    program_rand_a(0);
    for (int i = 0; i < 30; i++) begin
      want = !(i >= 11 && i <= 10 + LATA);
      n_tests++;
      if (a_cfg_ready !== want) begin
        n_fail++; $display("FAIL midstream_ready: beat %0d got %b required %b", i, a_cfg_ready, want);
      end
      d = rand_bus();
      cycle_a(1, d, route(PA, cfg_a[act_a], d), 0, 0, '0, (i == 10));
    end
    check_drained();
  endtask

  task automatic test_random_perm();
    logic [PA*DW-1:0] d;
    bit v;
    program_rand_a(1);
    for (int i = 0; i < 1000; i++) begin
      d = rand_bus();
      v = ($urandom_range(3) != 0);
      cycle_a(v, d, route(PA, cfg_a[act_a], d), 0, 0, '0, 0);
    end
    check_drained();
  endtask

  task automatic test_small_config();
    logic [PA*DW-1:0] d, e;
    bit v;
    for (int i = 0; i < 8; i++) begin
      d = rand_bus();
      cycle_b(1, d[PB*DW-1:0], d[PB*DW-1:0], 0, 0, '0, 0);
    end
    for (int s = 0; s < STB; s++) cycle_b(0, '0, '0, 1, s, 4'($urandom), 0);
    cycle_b(0, '0, '0, 0, 0, '0, 1);
    n_tests++; if (b_active !== 1'b1) begin n_fail++; $display("FAIL small_commit_bank: got %b required 1", b_active); end
    for (int i = 0; i < 300; i++) begin
      d = rand_bus();
      d[PA*DW-1:PB*DW] = '0;
      e = route(PB, cfg_b[act_b], d);
      v = ($urandom_range(3) != 0);
      cycle_b(v, d[PB*DW-1:0], e[PB*DW-1:0], 0, 0, '0, 0);
    end
    check_drained();
  endtask

  task automatic test_reset_midflight();
    logic [PA*DW-1:0] d;
    if (act_a !== 1'b1) program_rand_a(1);
    for (int i = 0; i < 5; i++) begin
      d = rand_bus();
      cycle_a(1, d, route(PA, cfg_a[act_a], d), 0, 0, '0, 0);
    end
    #2;
    rstn = 1'b0;
    q_a.delete(); q_b.delete();
    cfg_a[0] = '0; cfg_a[1] = '0; mask_a = '0; act_a = 1'b0;
    cfg_b[0] = '0; cfg_b[1] = '0; mask_b = '0; act_b = 1'b0;
    #1;
    n_tests++; if (a_ovalid !== 1'b0) begin n_fail++; $display("FAIL midreset_o_valid: got %b required 0", a_ovalid); end
    n_tests++; if (a_active !== 1'b0) begin n_fail++; $display("FAIL midreset_bank: got %b required 0", a_active); end
    n_tests++; if (a_odata !== '0) begin n_fail++; $display("FAIL midreset_o_data: got %h required 0", a_odata); end
    idle(2);
    rstn = 1'b1;
    idle(LATA + 3);
    for (int i = 0; i < 5; i++) begin
      d = rand_bus();
      cycle_a(1, d, d, 0, 0, '0, 0);
    end
    check_drained();
  endtask

  initial begin
    rstn = 1'b0;
    a_cfg_valid = 0; a_cfg_stage = '0; a_cfg_bits = '0; a_cfg_commit = 0; a_valid = 0; a_data = '0;
    b_cfg_valid = 0; b_cfg_stage = '0; b_cfg_bits = '0; b_cfg_commit = 0; b_valid = 0; b_data = '0;
    cfg_a[0] = '0; cfg_a[1] = '0; mask_a = '0; act_a = 1'b0;
    cfg_b[0] = '0; cfg_b[1] = '0; mask_b = '0; act_b = 1'b0;
    test_reset();
    test_identity();
    test_stage0_swap();
    test_cfg_errors();
    test_commit_midstream();
    test_random_perm();
    test_small_config();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/benes_pipe_router.md
Name: benes_pipe_router

Overview:
- Parametrised, pipelined N-port Benes interconnect that moves DATA_WIDTH beats between buffer RAM slots and arithmetic modules.
- Successor to the fixed 32-port combinational switch fabric.
- Adds per-stage pipeline registers, a double-buffered switch configuration loaded by a ready/valid handshake, and atomic commit.
- Every in-flight beat is routed with the configuration that was active when it entered.

Parameters:
PORTS, 32, number of ports; power of two, ≥4
DATA_WIDTH, 512, bits per port
PIPE_EVERY, 1, register after every PIPE_EVERY stages; output is always registered
Derived: LOGP=log2(PORTS), STAGES=2*LOGP-1, MID=LOGP-1, SW=PORTS/2, LAT=ceil(STAGES/PIPE_EVERY)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
i_cfg_valid  in  1  shadow-bank stage write request
o_cfg_ready  out  1  shadow bank writable
i_cfg_stage  in  clog2(STAGES)  stage index to write
i_cfg_bits  in  SW  cross bits; bit k drives switch k
i_cfg_commit  in  1  swap shadow and active banks
o_cfg_err  out  1  one-cycle pulse on a rejected write or commit
o_active_bank  out  1  current active bank index
i_valid  in  1  ingress beat valid
i_data  in  PORTS*DATA_WIDTH  port p at [p*DATA_WIDTH +: DATA_WIDTH]
o_valid  out  1  egress beat valid
o_data  out  PORTS*DATA_WIDTH  routed beat

Behaviour:
- Reset (asynchronous, any time including mid-flight):
  - o_valid=0, o_data=0, o_cfg_err=0, o_active_bank=0, o_cfg_ready=1.
  - Both banks all-zero, which is the identity permutation.
  - Written-mask cleared; all in-flight beats dropped.
- Switch: stage s, switch k takes ports 2k and 2k+1. Bit=0 passes straight; bit=1 swaps.
- Inter-stage wiring (output port p of stage s to the input of stage s+1):
  - s<MID: r=PORTS>>s, b=p-(p%r), q=p%r; dest=b+q/2+(q%2)*(r/2).
  - s≥MID: r=PORTS>>(STAGES-2-s), same b and q; dest=b+2*(q%(r/2))+q/(r/2).
- Pipeline:
  - Each beat carries a valid bit and a 1-bit bank tag equal to o_active_bank at ingress.
  - Stage s uses bank[tag][s].
  - Latency from i_valid to o_valid is exactly LAT cycles (PORTS=32, PIPE_EVERY=1 gives 9).
  - No backpressure; one beat per cycle is accepted.
- Config write:
  - Accepted when i_cfg_valid && o_cfg_ready.
  - Writes shadow[i_cfg_stage] and sets mask bit.
  - If i_cfg_stage ≥ STAGES: the write is ignored and o_cfg_err pulses.
  - A later write to the same stage overwrites it.
- Commit:
  - Accepted when i_cfg_commit && all STAGES mask bits are set, counting a write accepted in the same cycle.
  - On accept: o_active_bank toggles on the next edge and the mask clears.
  - The beat entering in the commit cycle uses the old bank; beats from the next cycle use the new bank.
  - Commit with an incomplete mask: ignored, o_cfg_err pulses.
- o_cfg_ready = 0 while any pipeline register holds a valid beat tagged with the shadow bank (~o_active_bank). It therefore drops for up to LAT cycles after a commit while old-bank beats drain.
- Invalid beats propagate data unchanged but are never tagged as occupying a bank.

Optional Feature:
- Macro BENES_BYPASS_EN adds input port i_bypass (1 bit).
- A beat with i_bypass=1 carries a bypass flag and is routed as identity (all switches straight) regardless of bank.
- A bypass beat never blocks o_cfg_ready.
- Without the macro the port does not exist and all beats use bank routing.

Test Plan:
- Reset, then beats with port p = p for 20 cycles → o_data identical 9 cycles later; o_valid follows i_valid.
- Write stage 0 all-ones and stages 1..8 zero, then commit; send port p = p → output ports 2k and 2k+1 swapped.
- Stream continuous beats, commit mid-stream → beats entering at or before the commit cycle use the old mapping, later beats the new; o_cfg_ready low for exactly the cycles needed to drain old-tag beats.
- Commit after writing only 8 stages → o_cfg_err pulse, o_active_bank unchanged. Write to stage 9 → o_cfg_err pulse, mask unchanged.
- Random full permutation programmed from a software Benes routing model on 1000 random beats → scoreboard matches; repeat with PORTS=8, PIPE_EVERY=2 (LAT=3).
- Deassert rstn with 5 beats in flight → o_valid=0 immediately, no beat emerges, o_active_bank=0, routing is identity.
